// File: rtl/sid_dac_pkg.sv
// Shared types and helpers for the sequential table-driven SID DAC.
package sid_dac_pkg;

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   localparam int DEF_SCALEBITS = 4;

   function automatic logic [63:0] ideal_weight(input int i, input int sb);
      return 64'd1 << (i + sb);
   endfunction

   // Wide enough to sum BITS full-scale entries plus the rounding constant.
   function automatic int acc_width(input int bits, input int sb);
      return bits + sb + $clog2(bits) + 1;
   endfunction

endpackage

// File: rtl/sid_dac_tbl.sv
// Per-bank, per-bit contribution register file with one write port and
// BPC combinational read ports addressed by bank and bit group.
module sid_dac_tbl
   import sid_dac_pkg::*;
#(
   parameter int BITS      = 12,
   parameter int SCALEBITS = DEF_SCALEBITS,
   parameter int BANKS     = 2,
   parameter int BPC       = 1,
   localparam int DW   = BITS + SCALEBITS,
   localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int IW   = $clog2(BITS),
   localparam int NGRP = BITS / BPC,
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [BW-1:0]           wr_bank,
   input  logic [IW-1:0]           wr_idx,
   input  logic [DW-1:0]           wr_data,
   input  logic [BW-1:0]           rd_bank,
   input  logic [GW-1:0]           rd_grp,
   output logic [BPC-1:0][DW-1:0]  rd_data
);

   logic [DW-1:0] tbl [BANKS][BITS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < BANKS; b++)
            for (int i = 0; i < BITS; i++)
               tbl[b][i] <= DW'(ideal_weight(i, SCALEBITS));
      end else if (we && (32'(wr_bank) < BANKS) && (32'(wr_idx) < BITS)) begin
         tbl[wr_bank][wr_idx] <= wr_data;
      end
   end

   // Reads see the flop contents, so a same-cycle write is not yet visible.
   always_comb begin
      logic [IW-1:0] idx;
      rd_data = '0;
      idx     = '0;
      for (int k = 0; k < BPC; k++) begin
         idx = IW'(32'(rd_grp) * BPC + k);
         if (32'(rd_bank) < BANKS)
            rd_data[k] = tbl[rd_bank][idx];
      end
   end

endmodule

// File: rtl/sid_dac_seq.sv
// Handshaked R-2R DAC model: accumulates BPC run-time table entries per clock,
// rounds, truncates and saturates, then returns the result with its tag.
module sid_dac_seq
   import sid_dac_pkg::*;
#(
   parameter int BITS      = 12,
   parameter int SCALEBITS = DEF_SCALEBITS,
   parameter int BANKS     = 2,
   parameter int BPC       = 1,
   parameter int TAGW      = 2,
   localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int IW = $clog2(BITS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BITS-1:0]           in_vin,
   input  logic [BW-1:0]             in_bank,
   input  logic [TAGW-1:0]           in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BITS-1:0]           out_vout,
   output logic [TAGW-1:0]           out_tag,
   input  logic                      tbl_we,
   input  logic [BW-1:0]             tbl_bank,
   input  logic [IW-1:0]             tbl_idx,
   input  logic [BITS+SCALEBITS-1:0] tbl_data
);

   localparam int AW   = acc_width(BITS, SCALEBITS);
   localparam int DW   = BITS + SCALEBITS;
   localparam int NGRP = BITS / BPC;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

   if (BITS % BPC != 0) begin : g_bpc_check
      $error("sid_dac_seq: BPC must divide BITS");
   end

   state_t                state;
   logic [BITS-1:0]       vin_r;
   logic [BW-1:0]         bank_r;
   logic                  bad_bank;
   logic [TAGW-1:0]       tag_r;
   logic [AW-1:0]         acc;
   logic [GW-1:0]         grp;
   logic [BPC-1:0][DW-1:0] rd_data;
   logic [BPC-1:0]        vin_grp;
   logic [AW-1:0]         acc_next;
   logic [AW-1:0]         acc_hi;
   logic [BITS-1:0]       result;
   logic                  accept;

   sid_dac_tbl #(
      .BITS      (BITS),
      .SCALEBITS (SCALEBITS),
      .BANKS     (BANKS),
      .BPC       (BPC)
   ) u_tbl (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (tbl_we),
      .wr_bank (tbl_bank),
      .wr_idx  (tbl_idx),
      .wr_data (tbl_data),
      .rd_bank (bank_r),
      .rd_grp  (grp),
      .rd_data (rd_data)
   );

   // A finished result may be swapped for a new request in the same cycle.
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      vin_grp  = BPC'(vin_r >> (32'(grp) * BPC));
      acc_next = acc;
      for (int k = 0; k < BPC; k++)
         if (vin_grp[k])
            acc_next = acc_next + AW'(rd_data[k]);
      acc_hi = acc_next >> (BITS + SCALEBITS);
      if (bad_bank)
         result = '0;
      else if (|acc_hi)
         result = '1;
      else
         result = acc_next[BITS+SCALEBITS-1:SCALEBITS];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         vin_r     <= '0;
         bank_r    <= '0;
         bad_bank  <= 1'b0;
         tag_r     <= '0;
         acc       <= '0;
         grp       <= '0;
         out_valid <= 1'b0;
         out_vout  <= '0;
         out_tag   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept)
                  state <= ACC;
            end
            ACC: begin
               acc <= acc_next;
               grp <= grp + 1'b1;
               if (grp == GW'(NGRP - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_vout  <= result;
                  out_tag   <= tag_r;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= accept ? ACC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Only possible in IDLE or on a DONE consume, so never clashes with ACC.
         if (accept) begin
            vin_r    <= in_vin;
            bank_r   <= in_bank;
            bad_bank <= !(32'(in_bank) < BANKS);
            tag_r    <= in_tag;
            acc      <= AW'(1) << (SCALEBITS - 1);
            grp      <= '0;
         end
      end
   end

endmodule

// File: doc/sid_dac_seq.md
Name: sid_dac_seq

Overview:
Sequential, table-driven R-2R DAC model that generalises the combinational SID DAC superposition. Per-bit contributions live in run-time writable banks, so 6581/8580 ladders are loaded by the host/CPU rather than precomputed for synthesis. Conversions are handshaked and accumulate BPC bits per clock. It sits between the SID voice/envelope/filter-cutoff logic and downstream consumers, and is shared by multiple requesters through a tag field.

Parameters:
BITS, 12, DAC input/output width (8, 11 and 12 used in the SID).
SCALEBITS, 4, fractional bits in table entries; rounding constant is 1<<(SCALEBITS-1).
BANKS, 2, number of independent bit-value tables (e.g. 0 = 8580 ideal, 1 = 6581 ladder).
BPC, 1, bits accumulated per clock; must divide BITS (elaboration error otherwise).
TAGW, 2, width of the opaque request tag returned with the result.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  conversion request.
in_ready  out  1  request accepted when in_valid && in_ready.
in_vin  in  BITS  digital input code.
in_bank  in  clog2(BANKS)  table bank to use.
in_tag  in  TAGW  tag returned with the result.
out_valid  out  1  result available.
out_ready  in  1  result consumed when out_valid && out_ready.
out_vout  out  BITS  converted code.
out_tag  out  TAGW  tag of the result.
tbl_we  in  1  table write strobe.
tbl_bank  in  clog2(BANKS)  bank to write.
tbl_idx  in  clog2(BITS)  bit index to write; idx >= BITS is ignored.
tbl_data  in  BITS+SCALEBITS  bit contribution scaled by 2^SCALEBITS.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, out_vout=0, out_tag=0. Every bank entry i is set to the ideal weight 1<<(i+SCALEBITS), so an unloaded block behaves as an ideal DAC (vout == vin).
- FSM IDLE -> ACC -> DONE:
  - IDLE: in_ready=1. On accept, latch vin/bank/tag, set acc = 1<<(SCALEBITS-1) and grp = 0, then go to ACC.
  - ACC: each clock, add tbl[bank][grp*BPC+k] for every k < BPC with vin[grp*BPC+k]=1, then grp++. After the group with grp = BITS/BPC-1, go to DONE.
  - DONE: out_valid=1, out_vout and out_tag held stable. in_ready = out_ready, so a new request can be accepted in the same cycle the result is consumed. On consume, go to ACC if a new request is accepted that cycle, otherwise IDLE.
- Latency: a request accepted at edge t gives out_valid=1 after edge t+BITS/BPC. Back-to-back throughput is one result per BITS/BPC+1 clocks at most, with no bubbles beyond that.
- Arithmetic: acc width is BITS+SCALEBITS+clog2(BITS)+1, unsigned. Result is acc[BITS+SCALEBITS-1:SCALEBITS] (round by truncation). If any acc bit at or above BITS+SCALEBITS is set, saturate out_vout to all ones.
- Table writes are accepted every cycle, including mid-conversion.
  - A read and a write to the same entry in the same cycle returns the old value.
  - An in-flight conversion uses the new value only for groups not yet processed.
  - in_bank >= BANKS or tbl_bank >= BANKS: the request still completes with result 0; the write is ignored.
- out_ready asserted with out_valid=0 has no effect. in_vin, in_bank and in_tag are don't-care unless in_valid=1.
- rst_n asserted mid-ACC or mid-DONE: the conversion is discarded, all outputs return to reset values, and tables return to ideal weights.

Decomposition:
- sid_dac_pkg:
  - state enum (IDLE, ACC, DONE).
  - localparam SCALEBITS default.
  - function ideal_weight(i) returning 1<<(i+SCALEBITS).
  - function acc_width(BITS).
- Sub-module sid_dac_tbl:
  - BANKS x BITS flop register file, reset to ideal weights.
  - One write port.
  - BPC combinational read ports addressed by (bank, grp).
- The top level holds the FSM, accumulator, saturation and handshake.

Test Plan:
- After reset, BPC=1, in_vin=0xABC, bank 0, tag 1 -> out_valid 12 clocks after accept, out_vout=0xABC, out_tag=1; vin=0x000 -> 0x000; vin=0xFFF -> 0xFFF.
- Write bank 1 entries 0..11 = 0x0010; vin=0xFFF -> 0x00C; vin=0x0A5 -> 0x004. Bank 0 unchanged: vin=0x0A5 -> 0x0A5.
- Bank 1 entries all 0xFFFF, vin=0x003 -> saturation to 0xFFF. A mid-conversion write of entry 11 to 0x0000 at grp=5 with vin=0x800 -> 0x000.
- out_ready held 1, two requests (tag 2 vin=0x100, tag 3 vin=0x200) -> results in order, 13 clocks apart. With out_ready=0 for 5 clocks, out_vout/out_tag stay stable and in_ready=0.
- BPC=4 build: vin=0x5A5 -> out_valid 3 clocks after accept, 0x5A5.
- rst_n pulsed low at grp=6 -> out_valid=0 and in_ready=1 immediately. Previously written bank 1 reads ideal again: vin=0x003 on bank 1 -> 0x003.
